// File: rtl/clk_monitor_if.sv
// Bundle between a clk_monitor and whoever programs its bounds and reads its results.
// The slave side is the monitor; the master side drives mon_clk, enable and bounds.
interface clk_monitor_if #(
  parameter int CNT_W = 16
);
  logic             mon_clk;
  logic             en;
  logic             err_clr;
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
  logic [CNT_W-1:0] high_min;
  logic [CNT_W-1:0] high_max;
  logic [CNT_W-1:0] jitter_max;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic [CNT_W-1:0] jitter;
  logic             win_vld;
  logic             period_err;
  logic             high_err;
  logic             jitter_err;
  logic             stuck_err;

  modport slave (
    input  mon_clk, en, err_clr, period_min, period_max, high_min, high_max, jitter_max,
    output period, high_time, period_vld, jitter, win_vld,
           period_err, high_err, jitter_err, stuck_err
  );

  modport master (
    output mon_clk, en, err_clr, period_min, period_max, high_min, high_max, jitter_max,
    input  period, high_time, period_vld, jitter, win_vld,
           period_err, high_err, jitter_err, stuck_err
  );
endinterface

// File: rtl/clk_monitor.sv
// Measures period, high time and windowed period spread of an asynchronous clock in
// system-clock cycles, with sticky bound-violation and stuck-clock flags.
module clk_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_monitor_if.slave  bus
);
  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_ARM   = 2'd1;
  localparam logic [1:0]       S_MEAS  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_det, fall_det;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    wmin_q, wmin_d, wmax_q, wmax_d;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    period_q, period_d, high_q, high_d, jit_q, jit_d;
  logic                pvld_q, pvld_d, wvld_q, wvld_d;
  logic                perr_q, herr_q, jerr_q, serr_q;
  logic                p_set, h_set, j_set, s_set;
  logic [CNT_W-1:0]    new_min, new_max, new_jit;

  assign rise_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_det = ~sync_q[SYNC_STAGES-1] & hist_q;

  // Both extremes include cnt_q, so max >= min and the difference never goes negative.
  assign new_min = (cnt_q < wmin_q) ? cnt_q : wmin_q;
  assign new_max = (cnt_q > wmax_q) ? cnt_q : wmax_q;
  assign new_jit = new_max - new_min;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wmin_d   = wmin_q;
    wmax_d   = wmax_q;
    wcnt_d   = wcnt_q;
    period_d = period_q;
    high_d   = high_q;
    jit_d    = jit_q;
    pvld_d   = 1'b0;
    wvld_d   = 1'b0;
    p_set    = 1'b0;
    h_set    = 1'b0;
    j_set    = 1'b0;
    s_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.en) state_d = S_ARM;
      end
      S_ARM: begin
        if (rise_det) begin
          cnt_d   = CNT_ONE;
          state_d = S_MEAS;
        end
      end
      S_MEAS: begin
        if (rise_det) begin
          period_d = cnt_q;
          pvld_d   = 1'b1;
          cnt_d    = CNT_ONE;
          p_set    = (cnt_q < bus.period_min) || (cnt_q > bus.period_max);
          wcnt_d   = wcnt_q + 1'b1;
          if (wcnt_q == {WIN_LOG2{1'b1}}) begin
            jit_d  = new_jit;
            wvld_d = 1'b1;
            j_set  = new_jit > bus.jitter_max;
            wmin_d = CNT_MAX;
            wmax_d = '0;
          end else begin
            wmin_d = new_min;
            wmax_d = new_max;
          end
        end else begin
          if (fall_det) begin
            high_d = cnt_q;
            h_set  = (cnt_q < bus.high_min) || (cnt_q > bus.high_max);
          end
          if (cnt_q == CNT_MAX) begin
            s_set   = 1'b1;
            state_d = S_ARM;
            wmin_d  = CNT_MAX;
            wmax_d  = '0;
            wcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable overrides everything, including an edge seen in the same cycle.
    if (!bus.en) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      wmin_d   = CNT_MAX;
      wmax_d   = '0;
      wcnt_d   = '0;
      period_d = period_q;
      high_d   = high_q;
      jit_d    = jit_q;
      pvld_d   = 1'b0;
      wvld_d   = 1'b0;
      p_set    = 1'b0;
      h_set    = 1'b0;
      j_set    = 1'b0;
      s_set    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wmin_q   <= CNT_MAX;
      wmax_q   <= '0;
      wcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      jit_q    <= '0;
      pvld_q   <= 1'b0;
      wvld_q   <= 1'b0;
      perr_q   <= 1'b0;
      herr_q   <= 1'b0;
      jerr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.mon_clk};
      hist_q   <= sync_q[SYNC_STAGES-1];
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wmin_q   <= wmin_d;
      wmax_q   <= wmax_d;
      wcnt_q   <= wcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      jit_q    <= jit_d;
      pvld_q   <= pvld_d;
      wvld_q   <= wvld_d;
      // A set in the same cycle as a clear wins.
      perr_q   <= p_set | (perr_q & ~bus.err_clr);
      herr_q   <= h_set | (herr_q & ~bus.err_clr);
      jerr_q   <= j_set | (jerr_q & ~bus.err_clr);
      serr_q   <= s_set | (serr_q & ~bus.err_clr);
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.period_vld = pvld_q;
  assign bus.jitter     = jit_q;
  assign bus.win_vld    = wvld_q;
  assign bus.period_err = perr_q;
  assign bus.high_err   = herr_q;
  assign bus.jitter_err = jerr_q;
  assign bus.stuck_err  = serr_q;
endmodule

// File: doc/clk_monitor.md
# clk_monitor

Synthesizable checker for a clock generated elsewhere in the design or applied from the bench. It samples an asynchronous monitored clock with the system clock and measures period, high time and period spread (jitter) in system-clock cycles. It also flags violations of programmable bounds and detects a stuck clock. It is the receive-side counterpart of the team's user-defined frequency/duty/jitter clock generator.

## Interface
- `CNT_W`, default 16: width of all cycle counts and bounds.
- `SYNC_STAGES`, default 2 (min 2): synchronizer depth for `mon_clk`.
- `WIN_LOG2`, default 3: jitter window is 2^WIN_LOG2 measured periods.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mon_clk`  in  1  monitored clock, asynchronous to `clk`; treated as data.
- `en`  in  1  measurement enable.
- `period_min`, `period_max`  in  CNT_W  allowed period range, inclusive.
- `high_min`, `high_max`  in  CNT_W  allowed high-time range, inclusive.
- `jitter_max`  in  CNT_W  allowed (max−min) period spread per window.
- `err_clr`  in  1  clears the sticky error flags.
- `period`  out  CNT_W  last measured period.
- `high_time`  out  CNT_W  last measured high time.
- `period_vld`  out  1  one-cycle pulse when `period` updates.
- `jitter`  out  CNT_W  max−min period of the last completed window.
- `win_vld`  out  1  one-cycle pulse when `jitter` updates.
- `period_err`, `high_err`, `jitter_err`, `stuck_err`  out  1 each  sticky flags.

## Operation
- Synchronizer: `SYNC_STAGES` flops, plus one history flop. `rise_det` = synced high and history low. `fall_det` is the inverse.
- FSM states:
  - IDLE: `en`=0; counters held at 0.
  - ARM: wait for first `rise_det`.
  - MEAS: measuring.
- FSM transitions:
  - IDLE→ARM when `en`=1.
  - ARM→MEAS on `rise_det`. The counter loads 1; no period is reported for this edge.
  - Any state→IDLE when `en`=0; the window is discarded and outputs are held.
  - MEAS→ARM on a stuck clock.
- Cycle counter `cnt`: loads 1 on `rise_det`; otherwise increments by 1 in MEAS.
- On `rise_det` in MEAS:
  - `period` ← `cnt`, `period_vld`=1.
  - Update window min/max and the window period count.
  - Set `period_err` if `cnt`<`period_min` or `cnt`>`period_max`.
- On `fall_det` in MEAS: `high_time` ← `cnt`. Set `high_err` if the value is outside [`high_min`,`high_max`].
- Window, after 2^WIN_LOG2 periods:
  - `jitter` ← max−min (unsigned, never negative); `win_vld`=1.
  - Set `jitter_err` if `jitter`>`jitter_max`.
  - min is reset to all-ones and max to 0 for the next window. The period completing a window belongs to that window.
- Stuck clock: if `cnt` reaches 2^CNT_W−1 in MEAS:
  - Set `stuck_err`.
  - Go to ARM and clear the window.
  - `cnt` never wraps.
- Sticky flags: hold until `err_clr`. If a set event and `err_clr` fall in the same cycle, set wins.
- Bound checks are unsigned. `period_min`>`period_max` flags every period.

## Timing
- Reset values: all outputs 0. FSM in IDLE, `cnt` 0, window min all-ones, window max 0, window count 0.
- Edge detect latency: `mon_clk` edge to `rise_det`/`fall_det` is SYNC_STAGES+1 `clk` cycles, ±1 for sampling uncertainty.
- `period`/`period_vld` and `high_time` update on the clock edge after the detect cycle, i.e. registered outputs.
- `win_vld` is asserted in the same cycle as the `period_vld` of the window's last period.
- Resolution is ±1 `clk` cycle per period.
- Monitored high and low phases must each be ≥2 `clk` cycles. Shorter pulses may be missed, and this is not flagged.
- `rst_n` asserted mid-measurement: everything returns to reset values immediately. After release the block re-arms from IDLE/ARM; there is no partial period.
- `en` deasserted in the same cycle as `rise_det`: IDLE wins and no `period_vld` is issued.

## Test plan
- **Basic measurement.** `mon_clk` = 10-cycle period, 3 cycles high; bounds 9..11 and 2..4.
  - No `period_vld` for the first rise.
  - Afterwards `period`=10 and `high_time`=3 every period; no error flags.
- **Jitter window.** WIN_LOG2=3, periods 10,12,9,10,11,10,10,10; `jitter_max`=2.
  - `win_vld` on the 8th `period_vld`; `jitter`=3; `jitter_err`=1.
  - Next window of constant 10s gives `jitter`=0, while `jitter_err` stays set (sticky).
- **Period violation and clear.** A 20-cycle period with `period_max`=11 sets `period_err`.
  - `err_clr` pulsed alone clears it.
  - `err_clr` in the same cycle as a new violation leaves it set.
- **Stuck clock.** CNT_W=8, `mon_clk` held high after lock.
  - `stuck_err` set when `cnt` reaches 255; FSM back in ARM.
  - Restarting `mon_clk` yields a correct `period` from the second rising edge.
- **Reset and enable.** `rst_n` low mid-period: all outputs 0 within the same cycle.
  - After release, the first `period_vld` comes from the second rising edge.
  - `en`=0 then 1 also discards the partial window.
